matmul_stream_ctrl: RTL and testbench

- Runtime-configurable successor to the fixed MxKxN streaming controller.
- Walks the MxN result space in tiles of LANES output columns and accumulates across K.
- Issues read addresses to the preloaded A/B memories, realigns returned data across a fixed memory latency, and streams operand beats to a LANES-wide PE row.
- Start/busy/done handshake toward the host; valid/ready toward the PEs; credit-based skid buffering so PE backpressure never drops in-flight reads.

---
 rtl/matmul_ctrl_pkg.sv | 25 ++
 rtl/ctrl_beat_fifo.sv | 57 +++++
 rtl/matmul_stream_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_matmul_stream_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/matmul_ctrl_pkg.sv
// Shared types for the streaming matmul controller: FSM states, per-beat
// sideband flags and a small sizing helper.
package matmul_ctrl_pkg;

    // Widest PE row the flag struct can describe; LANES must not exceed it.
    localparam int MAX_LANES = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic                 clear;
        logic                 last;
        logic [MAX_LANES-1:0] mask;
    } beat_flags_t;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/ctrl_beat_fifo.sv
// Synchronous beat FIFO. Exposes its occupancy so the issuer can run a
// credit scheme; push and pop in the same cycle are legal even when full.
module ctrl_beat_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             valid,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pop_ok   = pop && (count != '0);
    assign push_ok  = push && ((count != CNT_W'(DEPTH)) || pop_ok);
    assign pop_data = mem[rd_ptr];
    assign valid    = (count != '0);

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
            if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset because occupancy gates them
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/matmul_stream_ctrl.sv
// Runtime-configurable MxKxN streaming controller. Walks the result space in
// LANES-wide column tiles, issues A/B reads, realigns returned data over
// MEM_LAT cycles and streams beats to the PE row under credit flow control.
// Optional build macro: PERF_CNT_EN enables the busy/stall cycle counters.
module matmul_stream_ctrl
    import matmul_ctrl_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 32,
    parameter int LANES      = 4,
    parameter int DIM_W      = 16,
    parameter int MEM_LAT    = 1,
    parameter int FIFO_DEPTH = MEM_LAT + 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [DIM_W-1:0]        cfg_m,
    input  logic [DIM_W-1:0]        cfg_k,
    input  logic [DIM_W-1:0]        cfg_n,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic                    req,
    output logic [ADDR_W-1:0]       addr_a,
    output logic [ADDR_W-1:0]       addr_b,
    input  logic [DATA_W-1:0]       data_a,
    input  logic [LANES*DATA_W-1:0] data_b,
    output logic                    pe_in_valid,
    input  logic                    pe_ready,
    output logic [DATA_W-1:0]       pe_a,
    output logic [LANES*DATA_W-1:0] pe_b,
    output logic [LANES-1:0]        lane_mask,
    output logic                    clear_acc,
    output logic                    acc_last,
    output logic [31:0]             perf_busy_cyc,
    output logic [31:0]             perf_stall_cyc
);

    localparam int FLAG_W  = $bits(beat_flags_t);
    localparam int ENTRY_W = FLAG_W + DATA_W + LANES * DATA_W;
    localparam int FCNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int CNT_W   = FCNT_W + 1;

    state_t                  state;
    logic [DIM_W-1:0]        m_r, k_r, n_r;
    logic [DIM_W-1:0]        i_m, i_k, n0;
    logic [DIM_W:0]          n0_next;
    logic                    last_k, last_n, last_m, dims_zero;
    logic [CNT_W-1:0]        inflight, used;
    logic                    credit_ok, issue, push, pop;
    beat_flags_t             flags_issue, flags_p0;
    logic [MEM_LAT-1:0]      vld_p1;
    beat_flags_t             flags_p1 [MEM_LAT];
    logic [LANES*DATA_W-1:0] b_masked;
    logic [ENTRY_W-1:0]      push_word, head_word;
    logic                    fifo_valid;
    logic [FCNT_W-1:0]       fifo_count;
    beat_flags_t             head_flags;

    assign dims_zero = (cfg_m == '0) || (cfg_k == '0) || (cfg_n == '0);
    assign last_k    = (i_k == k_r - DIM_W'(1));
    assign n0_next   = {1'b0, n0} + (DIM_W + 1)'(LANES);
    assign last_n    = (n0_next >= {1'b0, n_r});
    assign last_m    = (i_m == m_r - DIM_W'(1));
    assign pop       = fifo_valid && pe_ready;
    assign used      = inflight + CNT_W'(fifo_count) - CNT_W'(pop);
    assign credit_ok = (used < CNT_W'(FIFO_DEPTH));
    assign issue     = (state == ISSUE) && credit_ok;

    // Sideband flags for the beat about to be issued
    always_comb begin
        flags_issue       = '0;
        flags_issue.clear = (i_k == '0);
        flags_issue.last  = last_k;
        for (int l = 0; l < LANES; l++) begin
            flags_issue.mask[l] = (({1'b0, n0} + (DIM_W + 1)'(l)) < {1'b0, n_r});
        end
    end

    // Control FSM: host handshake, tile walk and registered read requests
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            req      <= 1'b0;
            addr_a   <= '0;
            addr_b   <= '0;
            flags_p0 <= '0;
            m_r      <= '0;
            k_r      <= '0;
            n_r      <= '0;
            i_m      <= '0;
            i_k      <= '0;
            n0       <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            req  <= issue;
            case (state)
                IDLE: begin
                    if (start) begin
                        m_r <= cfg_m;
                        k_r <= cfg_k;
                        n_r <= cfg_n;
                        i_m <= '0;
                        i_k <= '0;
                        n0  <= '0;
                        if (dims_zero) begin
                            state <= DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state <= ISSUE;
                            busy  <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (issue) begin
                        addr_a   <= ADDR_W'(i_m) * ADDR_W'(k_r) + ADDR_W'(i_k);
                        addr_b   <= ADDR_W'(i_k) * ADDR_W'(n_r) + ADDR_W'(n0);
                        flags_p0 <= flags_issue;
                        if (last_k) begin
                            i_k <= '0;
                            if (last_n) begin
                                n0  <= '0;
                                i_m <= i_m + 1'b1;
                                if (last_m) state <= DRAIN;
                            end else begin
                                n0 <= n0_next[DIM_W-1:0];
                            end
                        end else begin
                            i_k <= i_k + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if ((inflight == '0) && !fifo_valid) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Outstanding reads: counted from issue until the beat lands in the FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= '0;
        end else begin
            case ({issue, push})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

    // ---- p0 -> p1: sideband valid travels MEM_LAT cycles behind req ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= '0;
        end else begin
            vld_p1[0] <= req;
            for (int i = 1; i < MEM_LAT; i++) vld_p1[i] <= vld_p1[i-1];
        end
    end

    // Sideband flags ride alongside the valid bits; data only, no reset
    always_ff @(posedge clk) begin
        flags_p1[0] <= flags_p0;
        for (int i = 1; i < MEM_LAT; i++) flags_p1[i] <= flags_p1[i-1];
    end

    // ---- p1 -> FIFO: returned data is captured with its flags ----
    always_comb begin
        b_masked = '0;
        for (int l = 0; l < LANES; l++) begin
            if (flags_p1[MEM_LAT-1].mask[l]) begin
                b_masked[l*DATA_W +: DATA_W] = data_b[l*DATA_W +: DATA_W];
            end
        end
    end

    assign push      = vld_p1[MEM_LAT-1];
    assign push_word = {flags_p1[MEM_LAT-1], data_a, b_masked};

    ctrl_beat_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (FCNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_word),
        .pop       (pop),
        .pop_data  (head_word),
        .valid     (fifo_valid),
        .count     (fifo_count)
    );

    // FIFO head presented to the PE row, forced to zero when empty
    always_comb begin
        head_flags  = head_word[ENTRY_W-1 -: FLAG_W];
        pe_in_valid = fifo_valid;
        pe_a        = fifo_valid ? head_word[LANES*DATA_W +: DATA_W] : '0;
        pe_b        = fifo_valid ? head_word[LANES*DATA_W-1:0] : '0;
        lane_mask   = fifo_valid ? head_flags.mask[LANES-1:0] : '0;
        clear_acc   = fifo_valid && head_flags.clear;
        acc_last    = fifo_valid && head_flags.last;
    end

`ifdef PERF_CNT_EN
    // Saturating busy/stall cycle counters, cleared on an accepted start
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_busy_cyc  <= '0;
            perf_stall_cyc <= '0;
        end else if ((state == IDLE) && start) begin
            perf_busy_cyc  <= '0;
            perf_stall_cyc <= '0;
        end else begin
            if (busy && (perf_busy_cyc != '1)) perf_busy_cyc <= perf_busy_cyc + 1'b1;
            if (fifo_valid && !pe_ready && (perf_stall_cyc != '1)) begin
                perf_stall_cyc <= perf_stall_cyc + 1'b1;
            end
        end
    end
`else
    assign perf_busy_cyc  = '0;
    assign perf_stall_cyc = '0;
`endif

endmodule

// File: tb/tb_matmul_stream_ctrl.sv
// Directed bench for matmul_stream_ctrl (MEM_LAT=3, LANES=4). A table of jobs
// is streamed through a latency-accurate memory model and every PE beat is
// checked against a golden beat sequence computed from M, K, N.
module tb_matmul_stream_ctrl;
    import matmul_ctrl_pkg::*;

    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 32;
    localparam int LANES   = 4;
    localparam int DIM_W   = 16;
    localparam int MEM_LAT = 3;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    start = 1'b0;
    logic [DIM_W-1:0]        cfg_m = '0, cfg_k = '0, cfg_n = '0;
    logic                    busy, done, err, req;
    logic [ADDR_W-1:0]       addr_a, addr_b;
    logic [DATA_W-1:0]       data_a;
    logic [LANES*DATA_W-1:0] data_b;
    logic                    pe_in_valid;
    logic                    pe_ready = 1'b1;
    logic [DATA_W-1:0]       pe_a;
    logic [LANES*DATA_W-1:0] pe_b;
    logic [LANES-1:0]        lane_mask;
    logic                    clear_acc, acc_last;
    logic [31:0]             perf_busy_cyc, perf_stall_cyc;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    matmul_stream_ctrl #(
        .DATA_W (DATA_W), .ADDR_W (ADDR_W), .LANES (LANES),
        .DIM_W (DIM_W), .MEM_LAT (MEM_LAT)
    ) dut (
        .clk (clk), .rst (rst), .start (start),
        .cfg_m (cfg_m), .cfg_k (cfg_k), .cfg_n (cfg_n),
        .busy (busy), .done (done), .err (err),
        .req (req), .addr_a (addr_a), .addr_b (addr_b),
        .data_a (data_a), .data_b (data_b),
        .pe_in_valid (pe_in_valid), .pe_ready (pe_ready),
        .pe_a (pe_a), .pe_b (pe_b), .lane_mask (lane_mask),
        .clear_acc (clear_acc), .acc_last (acc_last),
        .perf_busy_cyc (perf_busy_cyc), .perf_stall_cyc (perf_stall_cyc)
    );

    function automatic logic [7:0] mem_a(input int a);
        return 8'(a * 7 + 3);
    endfunction

    function automatic logic [7:0] mem_b(input int a);
        return 8'(a * 5 + 17);
    endfunction

    // Memory model: answers each req exactly MEM_LAT cycles later, garbage otherwise
    logic [MEM_LAT-1:0] h_vld = '0;
    logic [31:0]        h_a [MEM_LAT];
    logic [31:0]        h_b [MEM_LAT];

    always @(posedge clk) begin
        h_vld[0] <= req;
        h_a[0]   <= addr_a;
        h_b[0]   <= addr_b;
        for (int i = 1; i < MEM_LAT; i++) begin
            h_vld[i] <= h_vld[i-1];
            h_a[i]   <= h_a[i-1];
            h_b[i]   <= h_b[i-1];
        end
    end

    always_comb begin
        data_a = 8'hEE;
        data_b = {LANES{8'hDD}};
        if (h_vld[MEM_LAT-1]) begin
            data_a = mem_a(int'(h_a[MEM_LAT-1]));
            for (int l = 0; l < LANES; l++) data_b[l*8 +: 8] = mem_b(int'(h_b[MEM_LAT-1]) + l);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Golden beat: {clear, last, mask[3:0], a[7:0], b[31:0]}
    function automatic logic [45:0] exp_beat(input int idx, input int m, input int k, input int n);
        int tiles, kk, t, mm, n0;
        logic [3:0]  msk;
        logic [31:0] b;
        tiles = ceil_div(n, LANES);
        kk    = idx % k;
        t     = (idx / k) % tiles;
        mm    = idx / (k * tiles);
        n0    = t * LANES;
        b     = '0;
        for (int l = 0; l < LANES; l++) begin
            msk[l] = (n0 + l < n);
            if (msk[l]) b[l*8 +: 8] = mem_b(kk * n + n0 + l);
        end
        return {(kk == 0), (kk == k - 1), msk, mem_a(mm * k + kk), b};
    endfunction

    typedef struct {
        int m, k, n;
        int stall_after, stall_len;
        int exp_beats, exp_err, exp_stall;
    } vec_t;

    vec_t vecs [8];

    task automatic run_job(input vec_t v, input string tag);
        int beats = 0, reqs = 0, busy_cnt = 0, stall_cnt = 0, stall_left = 0, cyc = 0;
        bit finished = 0, prev_hold = 0;
        logic [46:0] snap = '0, cur;
        @(negedge clk);
        cfg_m = DIM_W'(v.m); cfg_k = DIM_W'(v.k); cfg_n = DIM_W'(v.n);
        start = 1'b1; pe_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (cyc = 0; cyc < 3000 && !finished; cyc++) begin
            if (cyc > 0) @(negedge clk);
            pe_ready = (stall_left > 0) ? 1'b0 : 1'b1;
            if (stall_left > 0) stall_left--;
            if (busy) busy_cnt++;
            if (req) reqs++;
            if (pe_in_valid && !pe_ready) stall_cnt++;
            cur = {pe_in_valid, clear_acc, acc_last, lane_mask, pe_a, pe_b};
            if (prev_hold) chk({tag, " hold"}, 64'(cur), 64'(snap));
            prev_hold = pe_in_valid && !pe_ready;
            snap = cur;
            if (pe_in_valid && pe_ready) begin
                if (beats >= v.exp_beats) chk({tag, " extra_beat"}, 64'(beats), 64'(v.exp_beats - 1));
                else chk($sformatf("%s beat%0d", tag, beats), 64'(cur[45:0]), 64'(exp_beat(beats, v.m, v.k, v.n)));
                beats++;
                if (beats == v.stall_after) stall_left = v.stall_len;
            end
            if (done) begin
                finished = 1;
                chk({tag, " err"}, 64'(err), 64'(v.exp_err));
                chk({tag, " busy_at_done"}, 64'(busy), 64'(0));
                if (v.exp_err != 0) chk({tag, " err_latency_ok"}, 64'(cyc <= 2), 64'(1));
`ifdef PERF_CNT_EN
                chk({tag, " perf_stall"}, 64'(perf_stall_cyc), 64'(v.exp_stall));
                chk({tag, " perf_busy"}, 64'(perf_busy_cyc), 64'(busy_cnt));
`else
                chk({tag, " perf_tied"}, 64'({perf_busy_cyc, perf_stall_cyc}), 64'(0));
`endif
            end
        end
        pe_ready = 1'b1;
        if (!finished) chk({tag, " done_timeout"}, 64'(0), 64'(1));
        chk({tag, " beats"}, 64'(beats), 64'(v.exp_beats));
        chk({tag, " reqs"}, 64'(reqs), 64'(v.exp_beats));
        chk({tag, " stall_cycles"}, 64'(stall_cnt), 64'(v.exp_stall));
    endtask

    initial begin
        int   rq;
        bit   seen;
        logic any_valid;

        //          m  k  n  st_after st_len beats err stall
        vecs[0] = '{2, 3, 4, -1,  0, 6, 0, 0};
        vecs[1] = '{1, 1, 6, -1,  0, 2, 0, 0};
        vecs[2] = '{2, 2, 6,  3, 10, 8, 0, 10};
        vecs[3] = '{1, 4, 4,  2,  5, 4, 0, 5};
        vecs[4] = '{3, 1, 5, -1,  0, 6, 0, 0};
        vecs[5] = '{1, 2, 3, -1,  0, 2, 0, 0};
        vecs[6] = '{2, 0, 4, -1,  0, 0, 1, 0};
        vecs[7] = '{0, 2, 2, -1,  0, 0, 1, 0};

        repeat (3) @(negedge clk);
        chk("reset_outputs",
            64'({busy, done, err, req, pe_in_valid, clear_acc, acc_last, lane_mask, pe_a, pe_b}), 64'(0));
        chk("reset_perf", 64'({perf_busy_cyc, perf_stall_cyc}), 64'(0));
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_job(vecs[i], $sformatf("job%0d", i));

        // Abandon a job with two reads outstanding, then run a clean one
        @(negedge clk);
        cfg_m = 2; cfg_k = 3; cfg_n = 4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rq = 0; seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (c > 0) @(negedge clk);
            if (req) rq++;
            if (rq == 2) seen = 1;
        end
        chk("rst_two_reqs_seen", 64'(seen), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_outputs",
            64'({busy, done, err, req, pe_in_valid, clear_acc, acc_last, lane_mask, pe_a, pe_b}), 64'(0));
        rst = 1'b0;
        any_valid = 1'b0;
        repeat (6) begin
            @(negedge clk);
            any_valid = any_valid | pe_in_valid | req | busy;
        end
        chk("rst_no_stale", 64'(any_valid), 64'(0));
        run_job(vecs[0], "post_rst");
        run_job(vecs[3], "post_rst_stall");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
